// File: rtl/tp_dis_loader.sv
// Two-point distance matrix loader: turns a host valid/ready stream into registered
// {from,to} writes broadcast to every node, expanding upper-triangle streams when asked.
module tp_dis_loader #(
  parameter int city_num     = 32,
  parameter int city_num_log = 5,
  parameter int dis_w        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      sym_mode,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [dis_w-1:0]          s_data,
  input  logic                      s_last,
  output logic                      tp_dis_write,
  output logic [2*city_num_log-1:0] tp_dis_waddr,
  output logic [dis_w-1:0]          tp_dis_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FULL   = 3'd1;
  localparam logic [2:0] ST_DIAG   = 3'd2;
  localparam logic [2:0] ST_UPPER  = 3'd3;
  localparam logic [2:0] ST_MIRROR = 3'd4;

  localparam logic [city_num_log-1:0] IDX_ZERO = '0;
  localparam logic [city_num_log-1:0] IDX_ONE  = city_num_log'(1);
  localparam logic [city_num_log-1:0] IDX_LAST = city_num_log'(city_num - 1);
  // Row of the last upper-triangle entry; the final symmetric beat is {IDX_PEN, IDX_LAST}.
  localparam logic [city_num_log-1:0] IDX_PEN  = city_num_log'(city_num - 2);

  logic [2:0]                state_q, state_d;
  logic [city_num_log-1:0]   i_q, i_d;
  logic [city_num_log-1:0]   j_q, j_d;
  logic [dis_w-1:0]          hold_q, hold_d;
  logic                      early_q, early_d;
  logic                      wr_q, wr_d;
  logic [2*city_num_log-1:0] waddr_q, waddr_d;
  logic [dis_w-1:0]          wdata_q, wdata_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      ready_c;
  logic                      full_final_c;
  logic                      sym_final_c;

  assign full_final_c = (i_q == IDX_LAST) && (j_q == IDX_LAST);
  assign sym_final_c  = (i_q == IDX_PEN) && (j_q == IDX_LAST);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    hold_d  = hold_q;
    early_d = early_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ready_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          i_d     = IDX_ZERO;
          j_d     = IDX_ZERO;
          early_d = 1'b0;
          state_d = sym_mode ? ST_DIAG : ST_FULL;
        end
      end

      ST_FULL: begin
        ready_c = 1'b1;
        if (s_valid) begin
          wr_d    = 1'b1;
          waddr_d = {i_q, j_q};
          wdata_d = s_data;
          if (full_final_c) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (!s_last) err_d = 1'b1;
          end else if (s_last) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else if (j_q == IDX_LAST) begin
            j_d = IDX_ZERO;
            i_d = i_q + IDX_ONE;
          end else begin
            j_d = j_q + IDX_ONE;
          end
        end
      end

      ST_DIAG: begin
        wr_d    = 1'b1;
        waddr_d = {i_q, i_q};
        wdata_d = '0;
        if (i_q == IDX_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          j_d     = i_q + IDX_ONE;
          state_d = ST_UPPER;
        end
      end

      ST_UPPER: begin
        ready_c = 1'b1;
        if (s_valid) begin
          wr_d    = 1'b1;
          waddr_d = {i_q, j_q};
          wdata_d = s_data;
          hold_d  = s_data;
          if (sym_final_c && !s_last) err_d = 1'b1;
          // An early s_last still owes its mirror write before the load aborts.
          early_d = s_last && !sym_final_c;
          state_d = ST_MIRROR;
        end
      end

      ST_MIRROR: begin
        wr_d    = 1'b1;
        waddr_d = {j_q, i_q};
        wdata_d = hold_q;
        if (early_q) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (j_q == IDX_LAST) begin
          i_d     = i_q + IDX_ONE;
          state_d = ST_DIAG;
        end else begin
          j_d     = j_q + IDX_ONE;
          state_d = ST_UPPER;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Busy covers the closing write (and its done pulse) before dropping.
    busy_d = (state_d != ST_IDLE) || wr_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      hold_q  <= '0;
      early_q <= 1'b0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      hold_q  <= hold_d;
      early_q <= early_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s_ready      = ready_c;
  assign tp_dis_write = wr_q;
  assign tp_dis_waddr = waddr_q;
  assign tp_dis_wdata = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
